// File: rtl/rob_param_if.sv
// Bundle of dispatch, operand query, writeback, store and commit signals
// between the out-of-order core and the reorder buffer.
interface rob_param_if #(
  parameter int DEPTH = 32,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             disp_valid_in;
  logic             disp_ready_out;
  logic [1:0]       disp_kind_in;
  logic [XLEN-1:0]  disp_pc_in;
  logic [REG_W-1:0] disp_rd_in;
  logic [IDX_W-1:0] disp_tag_out;

  logic [IDX_W-1:0] q1_tag_in;
  logic [IDX_W-1:0] q2_tag_in;
  logic             q1_rdy_out;
  logic             q2_rdy_out;
  logic [XLEN-1:0]  q1_data_out;
  logic [XLEN-1:0]  q2_data_out;

  logic             wb0_en_in;
  logic [IDX_W-1:0] wb0_tag_in;
  logic [XLEN-1:0]  wb0_value_in;
  logic [XLEN-1:0]  wb0_addr_in;
  logic             wb0_redirect_in;
  logic             wb1_en_in;
  logic [IDX_W-1:0] wb1_tag_in;
  logic [XLEN-1:0]  wb1_value_in;

  logic             mem_req_out;
  logic [XLEN-1:0]  mem_addr_out;
  logic [XLEN-1:0]  mem_wdata_out;
  logic             mem_ack_in;

  logic             reg_en_out;
  logic [REG_W-1:0] reg_rd_out;
  logic [IDX_W-1:0] reg_tag_out;
  logic [XLEN-1:0]  reg_value_out;
  logic             flush_out;
  logic [XLEN-1:0]  redirect_pc_out;
  logic [IDX_W:0]   count_out;

  modport master (
    output disp_valid_in, disp_kind_in, disp_pc_in, disp_rd_in,
    output q1_tag_in, q2_tag_in,
    output wb0_en_in, wb0_tag_in, wb0_value_in, wb0_addr_in, wb0_redirect_in,
    output wb1_en_in, wb1_tag_in, wb1_value_in,
    output mem_ack_in,
    input  disp_ready_out, disp_tag_out,
    input  q1_rdy_out, q2_rdy_out, q1_data_out, q2_data_out,
    input  mem_req_out, mem_addr_out, mem_wdata_out,
    input  reg_en_out, reg_rd_out, reg_tag_out, reg_value_out,
    input  flush_out, redirect_pc_out, count_out
  );

  modport slave (
    input  disp_valid_in, disp_kind_in, disp_pc_in, disp_rd_in,
    input  q1_tag_in, q2_tag_in,
    input  wb0_en_in, wb0_tag_in, wb0_value_in, wb0_addr_in, wb0_redirect_in,
    input  wb1_en_in, wb1_tag_in, wb1_value_in,
    input  mem_ack_in,
    output disp_ready_out, disp_tag_out,
    output q1_rdy_out, q2_rdy_out, q1_data_out, q2_data_out,
    output mem_req_out, mem_addr_out, mem_wdata_out,
    output reg_en_out, reg_rd_out, reg_tag_out, reg_value_out,
    output flush_out, redirect_pc_out, count_out
  );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: count-tracked circular queue with two writeback
// ports, operand bypass, and in-order retirement with flush and store handshake.
module rob_param #(
  parameter int DEPTH = 32,
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  rob_param_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_JUMP   = 2'd3
  } kind_e;

  typedef enum logic {ST_IDLE, ST_WAIT} st_e;

  logic [IDX_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] busy, rdy, redir;
  kind_e            kind  [DEPTH];
  logic [XLEN-1:0]  pc    [DEPTH];
  logic [XLEN-1:0]  value [DEPTH];
  logic [XLEN-1:0]  addr  [DEPTH];
  logic [REG_W-1:0] rd    [DEPTH];
  st_e              st_q, st_d;

  logic             reg_en_q, flush_q, mem_req_q;
  logic [REG_W-1:0] reg_rd_q;
  logic [IDX_W-1:0] reg_tag_q;
  logic [XLEN-1:0]  reg_value_q, redirect_pc_q, mem_addr_q, mem_wdata_q;

  logic             retire, do_reg, do_flush, mem_req_d;
  logic [XLEN-1:0]  mem_addr_d, mem_wdata_d;
  logic             disp_ready, disp_fire, wb0_hit, wb1_hit;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    st_d        = st_q;
    retire      = 1'b0;
    do_reg      = 1'b0;
    do_flush    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rdy_in) begin
      unique case (st_q)
        ST_IDLE: begin
          if (busy[head] && rdy[head]) begin
            unique case (kind[head])
              KIND_ALU: begin
                retire = 1'b1;
                do_reg = 1'b1;
              end
              KIND_BRANCH: begin
                retire   = 1'b1;
                do_flush = redir[head];
              end
              KIND_JUMP: begin
                retire   = 1'b1;
                do_reg   = 1'b1;
                do_flush = redir[head];
              end
              KIND_STORE: begin
                st_d        = ST_WAIT;
                mem_req_d   = 1'b1;
                mem_addr_d  = addr[head];
                mem_wdata_d = value[head];
              end
              default: ;
            endcase
          end
        end
        ST_WAIT: begin
          // Store retires only on ack; address and data stay as latched.
          if (bus.mem_ack_in) begin
            retire    = 1'b1;
            mem_req_d = 1'b0;
            st_d      = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // A flush about to happen closes dispatch so the younger op is not half-accepted.
  assign disp_ready = (count != CNT_W'(DEPTH)) && !do_flush;
  assign disp_fire  = bus.disp_valid_in && disp_ready && rdy_in;
  assign wb0_hit    = rdy_in && !do_flush && bus.wb0_en_in && busy[bus.wb0_tag_in];
  assign wb1_hit    = rdy_in && !do_flush && bus.wb1_en_in && busy[bus.wb1_tag_in]
                      && !(bus.wb0_en_in && bus.wb0_tag_in == bus.wb1_tag_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      rdy           <= '0;
      st_q          <= ST_IDLE;
      reg_en_q      <= 1'b0;
      reg_rd_q      <= '0;
      reg_tag_q     <= '0;
      reg_value_q   <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      reg_en_q <= do_reg;
      flush_q  <= do_flush;
      if (do_reg) begin
        reg_rd_q    <= rd[head];
        reg_tag_q   <= head;
        reg_value_q <= value[head];
      end
      if (do_flush) begin
        redirect_pc_q <= addr[head];
        head          <= '0;
        tail          <= '0;
        count         <= '0;
        busy          <= '0;
        rdy           <= '0;
        st_q          <= ST_IDLE;
        mem_req_q     <= 1'b0;
      end else begin
        st_q        <= st_d;
        mem_req_q   <= mem_req_d;
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
        if (disp_fire) begin
          busy[tail] <= 1'b1;
          rdy[tail]  <= 1'b0;
          tail       <= tail + IDX_W'(1);
        end
        if (wb0_hit) rdy[bus.wb0_tag_in] <= 1'b1;
        if (wb1_hit) rdy[bus.wb1_tag_in] <= 1'b1;
        if (retire) begin
          busy[head] <= 1'b0;
          rdy[head]  <= 1'b0;
          head       <= head + IDX_W'(1);
        end
        count <= count + CNT_W'(disp_fire) - CNT_W'(retire);
      end
    end
  end

  // NOTE: payload is qualified by busy/rdy, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (disp_fire) begin
      kind[tail]  <= kind_e'(bus.disp_kind_in);
      pc[tail]    <= bus.disp_pc_in;
      rd[tail]    <= bus.disp_rd_in;
      redir[tail] <= 1'b0;
    end
    if (wb0_hit) begin
      value[bus.wb0_tag_in] <= bus.wb0_value_in;
      addr[bus.wb0_tag_in]  <= bus.wb0_addr_in;
      redir[bus.wb0_tag_in] <= bus.wb0_redirect_in;
    end
    if (wb1_hit) value[bus.wb1_tag_in] <= bus.wb1_value_in;
  end

  logic [IDX_W-1:0] q_tag  [2];
  logic             q_rdy  [2];
  logic [XLEN-1:0]  q_data [2];

  assign q_tag[0] = bus.q1_tag_in;
  assign q_tag[1] = bus.q2_tag_in;

  // Operand lookup: stored result first, then same-cycle wb0, then wb1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_rdy[i]  = rdy[q_tag[i]]
                  || (bus.wb0_en_in && bus.wb0_tag_in == q_tag[i])
                  || (bus.wb1_en_in && bus.wb1_tag_in == q_tag[i]);
      q_data[i] = '0;
      if (rdy[q_tag[i]])                                    q_data[i] = value[q_tag[i]];
      else if (bus.wb0_en_in && bus.wb0_tag_in == q_tag[i]) q_data[i] = bus.wb0_value_in;
      else if (bus.wb1_en_in && bus.wb1_tag_in == q_tag[i]) q_data[i] = bus.wb1_value_in;
    end
  end

  assign bus.disp_ready_out  = disp_ready;
  assign bus.disp_tag_out    = tail;
  assign bus.q1_rdy_out      = q_rdy[0];
  assign bus.q2_rdy_out      = q_rdy[1];
  assign bus.q1_data_out     = q_data[0];
  assign bus.q2_data_out     = q_data[1];
  assign bus.mem_req_out     = mem_req_q;
  assign bus.mem_addr_out    = mem_addr_q;
  assign bus.mem_wdata_out   = mem_wdata_q;
  assign bus.reg_en_out      = reg_en_q;
  assign bus.reg_rd_out      = reg_rd_q;
  assign bus.reg_tag_out     = reg_tag_q;
  assign bus.reg_value_out   = reg_value_q;
  assign bus.flush_out       = flush_q;
  assign bus.redirect_pc_out = redirect_pc_q;
  assign bus.count_out       = count;
endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: directed stimulus pushes expected commit
// events; a negedge monitor pops and compares whenever the DUT emits one.
module tb_rob_param;
  localparam int DEPTH = 32;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_JMP = 2'd3;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic rdy_in   = 1'b1;

  rob_param_if #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) bus ();

  rob_param #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .rdy_in  (rdy_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic        r;
    logic        f;
    logic        m;
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] pc;
    logic [31:0] maddr;
    logic [31:0] mdata;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t ev_reg(input logic [4:0] tag, input logic [4:0] rd,
                                 input logic [31:0] value);
    ev_t e = '0;
    e.r = 1'b1; e.tag = tag; e.rd = rd; e.value = value;
    return e;
  endfunction

  function automatic logic [4:0] rd_of(input int i);
    return 5'((i + 3) % 32);
  endfunction

  // Monitor: one expected event per cycle that shows a commit pulse or a new store request.
  logic mem_prev = 1'b0;
  ev_t  mon_e;
  always @(negedge clk_in) begin
    if (rst_n_in && (bus.reg_en_out || bus.flush_out || (bus.mem_req_out && !mem_prev))) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {bus.reg_en_out, bus.flush_out, bus.mem_req_out}, 3'b000);
      end else begin
        mon_e = exp_q.pop_front();
        check("ev_type", {bus.reg_en_out, bus.flush_out, bus.mem_req_out && !mem_prev},
              {mon_e.r, mon_e.f, mon_e.m});
        if (mon_e.r) begin
          check("ev_reg_tag", bus.reg_tag_out, mon_e.tag);
          check("ev_reg_rd", bus.reg_rd_out, mon_e.rd);
          check("ev_reg_value", bus.reg_value_out, mon_e.value);
        end
        if (mon_e.f) check("ev_redirect_pc", bus.redirect_pc_out, mon_e.pc);
        if (mon_e.m) begin
          check("ev_mem_addr", bus.mem_addr_out, mon_e.maddr);
          check("ev_mem_wdata", bus.mem_wdata_out, mon_e.mdata);
        end
      end
    end
    mem_prev = bus.mem_req_out;
  end

  logic [4:0] mtail = '0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.disp_valid_in   = 1'b0;
    bus.disp_kind_in    = K_ALU;
    bus.disp_pc_in      = '0;
    bus.disp_rd_in      = '0;
    bus.q1_tag_in       = '0;
    bus.q2_tag_in       = '0;
    bus.wb0_en_in       = 1'b0;
    bus.wb0_tag_in      = '0;
    bus.wb0_value_in    = '0;
    bus.wb0_addr_in     = '0;
    bus.wb0_redirect_in = 1'b0;
    bus.wb1_en_in       = 1'b0;
    bus.wb1_tag_in      = '0;
    bus.wb1_value_in    = '0;
    bus.mem_ack_in      = 1'b0;
  endtask

  task automatic disp(input logic [1:0] k, input logic [4:0] r);
    bus.disp_valid_in = 1'b1;
    bus.disp_kind_in  = k;
    bus.disp_pc_in    = {25'd0, mtail, 2'b00};
    bus.disp_rd_in    = r;
    check("disp_tag", bus.disp_tag_out, mtail);
    tick();
    bus.disp_valid_in = 1'b0;
    mtail = mtail + 5'd1;
  endtask

  task automatic wb0_do(input logic [4:0] tag, input logic [31:0] v,
                        input logic [31:0] a, input logic redir);
    bus.wb0_en_in = 1'b1; bus.wb0_tag_in = tag; bus.wb0_value_in = v;
    bus.wb0_addr_in = a; bus.wb0_redirect_in = redir;
    tick();
    bus.wb0_en_in = 1'b0; bus.wb0_redirect_in = 1'b0;
  endtask

  task automatic wb1_do(input logic [4:0] tag, input logic [31:0] v);
    bus.wb1_en_in = 1'b1; bus.wb1_tag_in = tag; bus.wb1_value_in = v;
    tick();
    bus.wb1_en_in = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (bus.count_out != 0 && n < 200) begin
      tick();
      n++;
    end
    check(name, bus.count_out, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ev_t e;
    clear_inputs();

    // Reset state
    #12;
    check("rst_count", bus.count_out, 0);
    check("rst_ready", bus.disp_ready_out, 1);
    check("rst_tag", bus.disp_tag_out, 0);
    check("rst_reg_en", bus.reg_en_out, 0);
    check("rst_flush", bus.flush_out, 0);
    check("rst_mem_req", bus.mem_req_out, 0);
    rst_n_in = 1'b1;
    tick();

    // Fill all 32 slots
    for (int i = 0; i < DEPTH; i++) disp(K_ALU, rd_of(i));
    check("full_count", bus.count_out, 32);
    check("full_ready", bus.disp_ready_out, 0);
    bus.disp_valid_in = 1'b1;
    tick();
    bus.disp_valid_in = 1'b0;
    check("full_reject_count", bus.count_out, 32);
    check("full_reject_tag", bus.disp_tag_out, 0);

    // In-order retire of tags 0,1,2 written back in reverse
    exp_q.push_back(ev_reg(5'd0, rd_of(0), 32'h00));
    exp_q.push_back(ev_reg(5'd1, rd_of(1), 32'h11));
    exp_q.push_back(ev_reg(5'd2, rd_of(2), 32'h22));
    wb0_do(5'd2, 32'h22, 32'h0, 1'b0);
    wb1_do(5'd1, 32'h11);
    wb0_do(5'd0, 32'h00, 32'h0, 1'b0);
    check("full_retiring_ready", bus.disp_ready_out, 0);
    bus.disp_valid_in = 1'b1;
    tick();
    bus.disp_valid_in = 1'b0;
    check("retire0_pulse", bus.reg_en_out, 1);
    check("retire0_count", bus.count_out, 31);
    tick();
    check("retire1_pulse", bus.reg_en_out, 1);
    tick();
    check("retire2_pulse", bus.reg_en_out, 1);
    check("retire2_count", bus.count_out, 29);
    tick();
    check("retire_stall", bus.reg_en_out, 0);

    // Bypass and writeback-port priority
    bus.wb1_en_in = 1'b1; bus.wb1_tag_in = 5'd5; bus.wb1_value_in = 32'hDEAD;
    bus.q1_tag_in = 5'd5; bus.q2_tag_in = 5'd6;
    #1;
    check("bypass_q1_rdy", bus.q1_rdy_out, 1);
    check("bypass_q1_data", bus.q1_data_out, 32'hDEAD);
    check("bypass_q2_rdy", bus.q2_rdy_out, 0);
    check("bypass_q2_data", bus.q2_data_out, 0);
    tick();
    bus.wb1_en_in = 1'b0;
    #1;
    check("stored_q1_rdy", bus.q1_rdy_out, 1);
    check("stored_q1_data", bus.q1_data_out, 32'hDEAD);
    bus.wb0_en_in = 1'b1; bus.wb0_tag_in = 5'd6; bus.wb0_value_in = 32'h600;
    bus.wb1_en_in = 1'b1; bus.wb1_tag_in = 5'd6; bus.wb1_value_in = 32'h6666;
    #1;
    check("bypass_prio_data", bus.q2_data_out, 32'h600);
    tick();
    bus.wb0_en_in = 1'b0; bus.wb1_en_in = 1'b0;
    #1;
    check("wb_prio_stored", bus.q2_data_out, 32'h600);

    // Drain the rest in program order
    for (int t = 3; t < DEPTH; t++)
      exp_q.push_back(ev_reg(5'(t), rd_of(t),
                             t == 5 ? 32'hDEAD : t == 6 ? 32'h600 : 32'h1000 + t));
    for (int t = 3; t < DEPTH; t++) begin
      if (t == 5 || t == 6) continue;
      if (t % 2 == 0) wb1_do(5'(t), 32'h1000 + t);
      else            wb0_do(5'(t), 32'h1000 + t, 32'h0, 1'b0);
    end
    wait_empty("drain_count");

    // Mispredicted branch with ready younger ops and a same-cycle dispatch
    disp(K_BR, 5'd0);
    disp(K_ALU, rd_of(1));
    disp(K_ALU, rd_of(2));
    wb0_do(5'd1, 32'hA1, 32'h0, 1'b0);
    wb1_do(5'd2, 32'hA2);
    e = '0; e.f = 1'b1; e.pc = 32'h1000;
    exp_q.push_back(e);
    wb0_do(5'd0, 32'h0, 32'h1000, 1'b1);
    check("flush_pending_ready", bus.disp_ready_out, 0);
    check("pre_flush_count", bus.count_out, 3);
    bus.disp_valid_in = 1'b1;
    tick();
    bus.disp_valid_in = 1'b0;
    mtail = '0;
    check("flush_pulse", bus.flush_out, 1);
    check("flush_pc", bus.redirect_pc_out, 32'h1000);
    check("flush_count", bus.count_out, 0);
    check("flush_tail", bus.disp_tag_out, 0);
    tick();
    check("flush_pulse_end", bus.flush_out, 0);
    check("flush_dropped_disp", bus.count_out, 0);

    // Jump with redirect: register write and flush together
    disp(K_JMP, 5'd7);
    disp(K_ALU, rd_of(1));
    e = ev_reg(5'd0, 5'd7, 32'h104); e.f = 1'b1; e.pc = 32'h3000;
    exp_q.push_back(e);
    wb1_do(5'd1, 32'h77);
    wb0_do(5'd0, 32'h104, 32'h3000, 1'b1);
    tick();
    mtail = '0;
    check("jump_count", bus.count_out, 0);

    // Not-taken branch retires silently
    disp(K_BR, 5'd0);
    disp(K_ALU, rd_of(9));
    exp_q.push_back(ev_reg(5'd1, rd_of(9), 32'h99));
    wb0_do(5'd0, 32'h0, 32'h5000, 1'b0);
    wb1_do(5'd1, 32'h99);
    wait_empty("branch_nt_count");

    // Store with delayed ack, then a younger ALU
    disp(K_ST, 5'd0);
    disp(K_ALU, rd_of(3));
    e = '0; e.m = 1'b1; e.maddr = 32'h40; e.mdata = 32'h55;
    exp_q.push_back(e);
    exp_q.push_back(ev_reg(5'd3, rd_of(3), 32'h33));
    wb0_do(5'd2, 32'h55, 32'h40, 1'b0);
    wb1_do(5'd3, 32'h33);
    check("store_req", bus.mem_req_out, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("store_hold_req", bus.mem_req_out, 1);
      check("store_hold_addr", bus.mem_addr_out, 32'h40);
      check("store_hold_data", bus.mem_wdata_out, 32'h55);
      check("store_hold_block", bus.reg_en_out, 0);
    end
    rdy_in = 1'b0;
    tick();
    check("freeze_req", bus.mem_req_out, 1);
    check("freeze_count", bus.count_out, 2);
    rdy_in = 1'b1;
    bus.mem_ack_in = 1'b1;
    tick();
    bus.mem_ack_in = 1'b0;
    check("store_ack_req", bus.mem_req_out, 0);
    check("store_ack_count", bus.count_out, 1);
    tick();
    check("after_store_pulse", bus.reg_en_out, 1);
    check("after_store_tag", bus.reg_tag_out, 3);
    check("after_store_count", bus.count_out, 0);
    tick();

    // 40 dispatch/writeback pairs wrapping the tag space
    for (int i = 0; i < 40; i++) begin
      if (i == 20) check("wrap_steady_count", bus.count_out, 2);
      exp_q.push_back(ev_reg(mtail, rd_of(i), 32'h2000 + i));
      if (i > 0) begin
        bus.wb0_en_in = 1'b1; bus.wb0_tag_in = mtail - 5'd1;
        bus.wb0_value_in = 32'h2000 + i - 1; bus.wb0_addr_in = '0;
      end
      disp(K_ALU, rd_of(i));
      bus.wb0_en_in = 1'b0;
    end
    wb0_do(mtail - 5'd1, 32'h2000 + 39, 32'h0, 1'b0);
    wait_empty("wrap_count");
    check("wrap_tail", bus.disp_tag_out, 12);

    // Async reset in the middle of a store
    disp(K_ST, 5'd0);
    e = '0; e.m = 1'b1; e.maddr = 32'h80; e.mdata = 32'hBEEF;
    exp_q.push_back(e);
    wb0_do(5'd12, 32'hBEEF, 32'h80, 1'b0);
    begin
      int n = 0;
      while (!bus.mem_req_out && n < 10) begin
        tick();
        n++;
      end
    end
    check("rst_store_req", bus.mem_req_out, 1);
    @(negedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    check("arst_mem_req", bus.mem_req_out, 0);
    check("arst_mem_addr", bus.mem_addr_out, 0);
    check("arst_mem_data", bus.mem_wdata_out, 0);
    check("arst_count", bus.count_out, 0);
    check("arst_reg_value", bus.reg_value_out, 0);
    check("arst_reg_rd", bus.reg_rd_out, 0);
    check("arst_redirect", bus.redirect_pc_out, 0);
    check("arst_tag", bus.disp_tag_out, 0);
    check("sb_empty", exp_q.size(), 0);
    #10;
    rst_n_in = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
